// File: rtl/hazard_sequencer.sv
// Hazard-light sequencer: prescaled step pulse advancing a per-mode frame of LED
// patterns; mode requests are taken only at frame boundaries.
module hazard_sequencer #(
  parameter int TICK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic       hold,
  output logic [2:0] LEDR,
  output logic       step,
  output logic [1:0] mode_q
);

  localparam int CW = $clog2(8 * TICK_DIV);

  typedef enum logic [1:0] {
    CALM = 2'b00,
    R2L  = 2'b01,
    L2R  = 2'b10,
    OFF  = 2'b11
  } mode_t;

  logic [3:0]    sw_meta, sw_sync;
  logic          hold_meta, hold_sync;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    idx_reg, idx_next;
  mode_t         mode_reg, mode_next;
  logic          step_reg, step_next;
  logic [31:0]   period;
  logic [1:0]    last_idx;
  logic          fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      hold_meta <= hold;
      hold_sync <= hold_meta;
    end
  end

  // Period follows the live speed select, so a faster speed can fire at once.
  always_comb begin
    period = 32'(TICK_DIV) << (2'd3 - sw_sync[3:2]);
    fire   = !hold_sync && (32'(count_reg) >= (period - 32'd1));
  end

  always_comb begin
    last_idx = 2'd0;
    case (mode_reg)
      CALM:    last_idx = 2'd1;
      R2L:     last_idx = 2'd2;
      L2R:     last_idx = 2'd2;
      OFF:     last_idx = 2'd0;
      default: last_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      idx_reg   <= 2'd0;
      mode_reg  <= CALM;
      step_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      idx_reg   <= idx_next;
      mode_reg  <= mode_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    idx_next   = idx_reg;
    mode_next  = mode_reg;
    step_next  = 1'b0;
    if (fire) begin
      count_next = '0;
      step_next  = 1'b1;
      if (idx_reg > last_idx) begin
        idx_next = 2'd0;
      end else if (idx_reg == last_idx) begin
        // Frame boundary: the only point where a new mode is accepted.
        idx_next  = 2'd0;
        mode_next = mode_t'(sw_sync[1:0]);
      end else begin
        idx_next = idx_reg + 2'd1;
      end
    end else if (!hold_sync) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_comb begin
    LEDR = 3'b000;
    case (mode_reg)
      CALM: begin
        case (idx_reg)
          2'd0:    LEDR = 3'b101;
          2'd1:    LEDR = 3'b010;
          default: LEDR = 3'b000;
        endcase
      end
      R2L: begin
        case (idx_reg)
          2'd0:    LEDR = 3'b001;
          2'd1:    LEDR = 3'b010;
          2'd2:    LEDR = 3'b100;
          default: LEDR = 3'b000;
        endcase
      end
      L2R: begin
        case (idx_reg)
          2'd0:    LEDR = 3'b100;
          2'd1:    LEDR = 3'b010;
          2'd2:    LEDR = 3'b001;
          default: LEDR = 3'b000;
        endcase
      end
      default: LEDR = 3'b000;
    endcase
  end

  assign step   = step_reg;
  assign mode_q = mode_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer at TICK_DIV=2: per-cycle vector table plus
// hand-written hold, speed-change, off-mode and asynchronous-reset sequences.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] SW = 4'b1100;
  logic       hold = 1'b0;
  logic [2:0] LEDR;
  logic       step;
  logic [1:0] mode_q;

  int tests = 0;
  int fails = 0;

  hazard_sequencer #(.TICK_DIV(2)) dut (
    .clk(clk),
    .reset(reset),
    .SW(SW),
    .hold(hold),
    .LEDR(LEDR),
    .step(step),
    .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [2:0] led;
    logic [1:0] mode;
    logic       stp;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t v(input logic [3:0] sw, input logic [2:0] led,
                             input logic [1:0] mode, input logic stp);
    vec_t r;
    r.sw = sw; r.led = led; r.mode = mode; r.stp = stp;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_step(input string name, input int exp_n,
                           input logic [2:0] exp_led, input logic [1:0] exp_mode);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 64);
    check({name, "_ticks"}, n, exp_n);
    check({name, "_led"}, LEDR, exp_led);
    check({name, "_mode"}, mode_q, exp_mode);
    $display("[TB] %s: step after %0d cycles LEDR=%b mode_q=%b", name, n, LEDR, mode_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Calm, then request right-to-left, then left-to-right; spd=3 (step every 2 cycles).
    vecs[0]  = v(4'b1100, 3'b101, 2'd0, 1'b0);
    vecs[1]  = v(4'b1100, 3'b101, 2'd0, 1'b0);
    vecs[2]  = v(4'b1100, 3'b010, 2'd0, 1'b1);
    vecs[3]  = v(4'b1100, 3'b010, 2'd0, 1'b0);
    vecs[4]  = v(4'b1100, 3'b101, 2'd0, 1'b1);
    vecs[5]  = v(4'b1100, 3'b101, 2'd0, 1'b0);
    vecs[6]  = v(4'b1100, 3'b010, 2'd0, 1'b1);
    vecs[7]  = v(4'b1100, 3'b010, 2'd0, 1'b0);
    vecs[8]  = v(4'b1100, 3'b101, 2'd0, 1'b1);
    vecs[9]  = v(4'b1101, 3'b101, 2'd0, 1'b0);
    vecs[10] = v(4'b1101, 3'b010, 2'd0, 1'b1);
    vecs[11] = v(4'b1101, 3'b010, 2'd0, 1'b0);
    vecs[12] = v(4'b1101, 3'b001, 2'd1, 1'b1);
    vecs[13] = v(4'b1101, 3'b001, 2'd1, 1'b0);
    vecs[14] = v(4'b1101, 3'b010, 2'd1, 1'b1);
    vecs[15] = v(4'b1101, 3'b010, 2'd1, 1'b0);
    vecs[16] = v(4'b1101, 3'b100, 2'd1, 1'b1);
    vecs[17] = v(4'b1101, 3'b100, 2'd1, 1'b0);
    vecs[18] = v(4'b1101, 3'b001, 2'd1, 1'b1);
    vecs[19] = v(4'b1101, 3'b001, 2'd1, 1'b0);
    vecs[20] = v(4'b1101, 3'b010, 2'd1, 1'b1);
    vecs[21] = v(4'b1110, 3'b010, 2'd1, 1'b0);
    vecs[22] = v(4'b1110, 3'b100, 2'd1, 1'b1);
    vecs[23] = v(4'b1110, 3'b100, 2'd1, 1'b0);
    vecs[24] = v(4'b1110, 3'b100, 2'd2, 1'b1);
    vecs[25] = v(4'b1110, 3'b100, 2'd2, 1'b0);
    vecs[26] = v(4'b1110, 3'b010, 2'd2, 1'b1);
    vecs[27] = v(4'b1110, 3'b010, 2'd2, 1'b0);
    vecs[28] = v(4'b1110, 3'b001, 2'd2, 1'b1);
    vecs[29] = v(4'b1110, 3'b001, 2'd2, 1'b0);
    vecs[30] = v(4'b1110, 3'b100, 2'd2, 1'b1);

    tick();
    tick();
    check("reset_state", {LEDR, mode_q, step}, {3'b101, 2'd0, 1'b0});
    $display("[TB] reset: LEDR=%b mode_q=%b step=%b", LEDR, mode_q, step);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      SW = vecs[i].sw;
      tick();
      check($sformatf("vec%0d", i), {LEDR, mode_q, step},
            {vecs[i].led, vecs[i].mode, vecs[i].stp});
      $display("[TB] vec%0d: SW=%b LEDR=%b mode_q=%b step=%b", i, SW, LEDR, mode_q, step);
    end

    // spd=0: 16 cycles per step, first step 16 cycles after reset release.
    reset = 1'b1;
    SW = 4'b0000;
    tick();
    reset = 1'b0;
    wait_step("spd0_first", 16, 3'b010, 2'd0);
    wait_step("spd0_second", 16, 3'b101, 2'd0);

    // Hold for 10 cycles with count at 5.
    for (int i = 0; i < 5; i++) tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d", i), {LEDR, mode_q, step}, {3'b101, 2'd0, 1'b0});
    end
    $display("[TB] hold: 10 cycles frozen LEDR=%b mode_q=%b", LEDR, mode_q);
    hold = 1'b0;
    wait_step("hold_release", 11, 3'b010, 2'd0);

    // Speed 0->3 reaching the synchronized domain while count is 5.
    for (int i = 0; i < 3; i++) tick();
    SW = 4'b1100;
    tick();
    check("spd_switch_c1", step, 1'b0);
    tick();
    check("spd_switch_c2", step, 1'b0);
    tick();
    check("spd_switch_fire", {LEDR, mode_q, step}, {3'b101, 2'd0, 1'b1});
    $display("[TB] spd switch: step=%b LEDR=%b", step, LEDR);
    wait_step("spd3_next", 2, 3'b010, 2'd0);

    // Off mode from the next boundary; every step re-samples the request.
    SW = 4'b1111;
    wait_step("off_a", 2, 3'b101, 2'd0);
    wait_step("off_b", 2, 3'b010, 2'd0);
    wait_step("off_c", 2, 3'b000, 2'd3);
    wait_step("off_d", 2, 3'b000, 2'd3);
    SW = 4'b1101;
    wait_step("off_e", 2, 3'b000, 2'd3);
    wait_step("r2l_a", 2, 3'b001, 2'd1);
    wait_step("r2l_b", 2, 3'b010, 2'd1);
    wait_step("r2l_c", 2, 3'b100, 2'd1);

    // Asynchronous reset between edges during right-to-left idx2.
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {LEDR, mode_q, step}, {3'b101, 2'd0, 1'b0});
    $display("[TB] async reset: LEDR=%b mode_q=%b step=%b", LEDR, mode_q, step);
    tick();
    reset = 1'b0;
    wait_step("post_reset_first", 3, 3'b010, 2'd0);
    wait_step("post_reset_boundary", 2, 3'b001, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6250000; base step period in clk cycles; legal range 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port SW, input, 4 bits: SW[1:0] is the mode request (00 calm, 01 right-to-left, 10 left-to-right, 11 off); SW[3:2] is the speed select spd.
REQ-005 SHALL have port hold, input, 1 bit: 1 freezes the sequence.
REQ-006 SHALL have port LEDR, output, 3 bits: light pattern.
REQ-007 SHALL have port step, output, 1 bit: one-cycle pulse on each pattern advance.
REQ-008 SHALL have port mode_q, output, 2 bits: active mode encoding.

Function
REQ-009 SHALL pass SW and hold through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-010 SHALL compute the step period as P = TICK_DIV << (3 - spd), i.e. 8x, 4x, 2x or 1x TICK_DIV for spd 0..3.
REQ-011 SHALL keep a prescaler count, width ceil(log2(8*TICK_DIV)), that increments each cycle while hold=0.
REQ-012 SHALL assert step for exactly one cycle when count >= P-1 and hold=0, and reset count to 0 on that same edge.
REQ-013 SHALL let an spd change take effect on the current count; if count >= new P-1, step SHALL fire on the next cycle.
REQ-014 SHALL hold count, frame index idx, mode_q and LEDR unchanged while hold=1, and keep step at 0.
REQ-015 SHALL use frame lengths N of calm=2, right-to-left=3, left-to-right=3, off=1.
REQ-016 SHALL, on step with idx < N-1, increment idx and keep mode_q.
REQ-017 SHALL, on step with idx = N-1 (frame boundary), set mode_q to the synchronized SW[1:0] and idx to 0; a mode change SHALL never occur mid-frame.
REQ-018 SHALL, on step at a boundary where the request equals mode_q, wrap idx to 0 with no other effect.
REQ-019 SHALL drive LEDR as a pure Moore decode of the mode_q/idx registers:
- calm: 101, 010
- right-to-left: 001, 010, 100
- left-to-right: 100, 010, 001
- off: 000
REQ-020 SHALL keep idx in 0..N-1 for the active mode; any illegal idx SHALL decode LEDR=000 and SHALL be forced to 0 on the next step.

Reset
REQ-021 SHALL, while reset=1 and independent of clk, immediately force mode_q=00, idx=0, count=0, step=0, synchronizer flops=0 and LEDR=101.
REQ-022 SHALL, after reset deasserts, produce the first step P cycles later; reset mid-frame SHALL discard the frame and any pending request.

Verification (TICK_DIV=2)
REQ-023 SHALL cover: reset, then SW=1100, hold=0 -> LEDR alternates 101/010 every 2 cycles; step pulses every 2nd cycle.
REQ-024 SHALL cover: calm at idx0, SW[1:0]=01 -> next step LEDR=010, following step 001, then 010, 100, 001 repeating; mode_q becomes 01 only at the boundary.
REQ-025 SHALL cover: right-to-left at idx1 (LEDR=010), SW[1:0]=10 -> next step 100 (R2L idx2), following step 100 (L2R idx0), then 010, 001.
REQ-026 SHALL cover: hold=1 for 10 cycles mid-count -> LEDR, count and mode_q frozen, step=0; on release the remaining count completes before the next step.
REQ-027 SHALL cover: spd=0 gives 16 cycles between steps; switching spd 0->3 at count 5 -> step on the next cycle; SW[1:0]=11 -> LEDR=000 from the next boundary, each step re-samples the mode.
REQ-028 SHALL cover: async reset asserted between edges during right-to-left idx2 -> LEDR=101 and mode_q=00 before the next clk edge.
